mmul_stream_feeder: RTL and testbench

- AXI-Stream master that drives the systolic-array top's slave stream (s_axis_*) and its load_weight strobe.
- The host preloads N weight rows and up to DEPTH activation rows into local register files, then issues start.
- The feeder sequences: weight load (optional), activation rows, then zero flush rows. The flush rows are needed because the array only advances on accepted beats.
- Sits between host/CPU register interface and the accelerator input.

---
 rtl/mmul_stream_feeder_pkg.sv | 35 +++
 rtl/mmul_stream_feeder_if.sv | 20 ++
 rtl/mmul_row_regfile.sv | 32 +++
 rtl/mmul_stream_feeder.sv | 181 ++++++++++++++++++
 tb/tb_mmul_stream_feeder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmul_stream_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mmul_stream_feeder_pkg
// Purpose  : Shared phase encoding, default row geometry and sizing helpers
//            for the systolic-array stream feeder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package mmul_stream_feeder_pkg;

   // Job phase; also the FSM state of the feeder.
   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_WEIGHT = 3'd1,
      PH_ACT    = 3'd2,
      PH_FLUSH  = 3'd3,
      PH_DONE   = 3'd4
   } phase_t;

   localparam int C_N          = 4;
   localparam int C_DATA_WIDTH = 8;
   localparam int C_ROW_W      = C_N * C_DATA_WIDTH;

   // Address width for a memory of 'depth' entries, never below one bit.
   function automatic int addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmul_stream_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mmul_stream_feeder_if
// Purpose  : Row-beat AXI-Stream link from the feeder to the array input.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface mmul_stream_feeder_if
   import mmul_stream_feeder_pkg::*;
#(
   parameter int ROW_W = C_ROW_W
) ();
   logic [ROW_W-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tuser;

   modport master (output tdata, output tvalid, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/mmul_row_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mmul_row_regfile
// Purpose  : Row register file, synchronous write, combinational read.
//            Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mmul_row_regfile
   import mmul_stream_feeder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ROW_W = 32
) (
   input  wire logic                     clk,
   input  wire logic                     we,
   input  wire logic [addr_w(DEPTH)-1:0] waddr,
   input  wire logic [ROW_W-1:0]         wdata,
   input  wire logic [addr_w(DEPTH)-1:0] raddr,
   output      logic [ROW_W-1:0]         rdata
);
   logic [ROW_W-1:0] mem_q [DEPTH];

   // Row write; callers guarantee waddr is in range.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule
`default_nettype wire

// File: rtl/mmul_stream_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mmul_stream_feeder
// Purpose  : Streams weight rows (optional, N-1 down to 0), activation rows
//            and zero flush rows into the systolic array over AXI-Stream.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mmul_stream_feeder
   import mmul_stream_feeder_pkg::*;
#(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FLUSH      = 2 * N + 1
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   input  wire logic                       wr_en,
   input  wire logic                       wr_sel,
   input  wire logic [addr_w(DEPTH)-1:0]   wr_addr,
   input  wire logic [N*DATA_WIDTH-1:0]    wr_data,
   input  wire logic                       start,
   input  wire logic                       reload_w,
   input  wire logic [addr_w(DEPTH):0]     num_rows,
   mmul_stream_feeder_if.master            m_axis,
   output      logic                       load_weight,
   output      logic                       busy,
   output      logic                       done
);
   localparam int ROW_W = N * DATA_WIDTH;
   localparam int AW    = addr_w(DEPTH);
   localparam int WAW   = addr_w(N);
   localparam int RW    = AW + 1;
   localparam int CW    = $clog2(max3(N, DEPTH, FLUSH) + 1);

   phase_t           state_q, state_d, ph, next_ph;
   logic [CW-1:0]    cnt_q, cnt_d, cnt, total;
   logic [RW-1:0]    rows_q, rows_d, rows, rows_in;
   logic [ROW_W-1:0] tdata_q, tdata_d, beat_data;
   logic             tvalid_q, tvalid_d;
   logic             tuser_q, tuser_d;
   logic             lw_q, lw_d;
   logic             is_final, has_beat, load, accept;

   logic             w_we, a_we;
   logic [WAW-1:0]   w_raddr;
   logic [AW-1:0]    a_raddr;
   logic [ROW_W-1:0] w_rdata, a_rdata;

   // Host writes are dropped while a job runs or when out of range.
   assign w_we = wr_en && !busy &&  wr_sel && (int'(wr_addr) < N);
   assign a_we = wr_en && !busy && !wr_sel && (int'(wr_addr) < DEPTH);

   mmul_row_regfile #(.DEPTH(N), .ROW_W(ROW_W)) u_wmem (
      .clk   (clk),
      .we    (w_we),
      .waddr (WAW'(wr_addr)),
      .wdata (wr_data),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );

   mmul_row_regfile #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_amem (
      .clk   (clk),
      .we    (a_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (a_raddr),
      .rdata (a_rdata)
   );

   // Weights go out last row first; activations in ascending order.
   assign w_raddr = WAW'(CW'(N - 1) - cnt);
   assign a_raddr = AW'(cnt);

   // Phase sequencing and next-beat selection. A start in IDLE is folded
   // into the current phase so the first beat loads in the accept cycle.
   always_comb begin
      rows_in  = (int'(num_rows) > DEPTH) ? RW'(DEPTH) : num_rows;
      ph       = state_q;
      cnt      = cnt_q;
      rows     = rows_q;
      if (state_q == PH_IDLE && start) begin
         cnt  = '0;
         rows = rows_in;
         if (reload_w)          ph = PH_WEIGHT;
         else if (rows_in != 0) ph = PH_ACT;
         else                   ph = PH_DONE;
      end

      total     = '0;
      next_ph   = PH_DONE;
      is_final  = 1'b0;
      beat_data = '0;
      case (ph)
         PH_WEIGHT: begin
            total     = CW'(N);
            next_ph   = PH_ACT;
            is_final  = (rows == 0);
            beat_data = w_rdata;
         end
         PH_ACT: begin
            total     = CW'(rows);
            next_ph   = PH_FLUSH;
            is_final  = (FLUSH == 0);
            beat_data = a_rdata;
         end
         PH_FLUSH: begin
            total     = CW'(FLUSH);
            is_final  = 1'b1;
         end
         default: ;
      endcase

      has_beat = (ph == PH_WEIGHT || ph == PH_ACT || ph == PH_FLUSH) && (cnt < total);
      accept   = tvalid_q && m_axis.tready;
      load     = has_beat && (!tvalid_q || m_axis.tready);

      state_d  = ph;
      cnt_d    = cnt;
      rows_d   = rows;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tuser_d  = tuser_q;
      lw_d     = lw_q;

      if (state_q == PH_DONE) begin
         state_d = PH_IDLE;
      end

      if (load) begin
         tdata_d  = beat_data;
         tvalid_d = 1'b1;
         tuser_d  = (ph == PH_FLUSH);
         lw_d     = (ph == PH_WEIGHT);
         cnt_d    = cnt + CW'(1);
         if ((cnt + CW'(1)) == total && !is_final) begin
            state_d = next_ph;
            cnt_d   = '0;
         end
      end else if (accept) begin
         tvalid_d = 1'b0;
         tuser_d  = 1'b0;
         lw_d     = 1'b0;
      end

      // Last beat of the job accepted: finish together with the handshake.
      if (is_final && (ph != PH_DONE) && (ph != PH_IDLE) && cnt == total && accept) begin
         state_d = PH_DONE;
      end
   end

   // State, counters and the single output register stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= PH_IDLE;
         cnt_q    <= '0;
         rows_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         lw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rows_q   <= rows_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         lw_q     <= lw_d;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tuser  = tuser_q;
   assign load_weight   = lw_q;
   assign busy          = (state_q != PH_IDLE);
   assign done          = (state_q == PH_DONE);
endmodule
`default_nettype wire

// File: tb/tb_mmul_stream_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mmul_stream_feeder
// Purpose  : Self-checking bench for mmul_stream_feeder against a queue model
//            of the expected beat stream.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mmul_stream_feeder;
   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int FL    = 2 * N + 1;
   localparam int RW    = N * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [3:0]    wr_addr = '0;
   logic [RW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          reload_w = 1'b0;
   logic [4:0]    num_rows = '0;
   logic          load_weight, busy, done;

   mmul_stream_feeder_if #(.ROW_W(RW)) axis ();

   mmul_stream_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .reload_w    (reload_w),
      .num_rows    (num_rows),
      .m_axis      (axis),
      .load_weight (load_weight),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Reference memories and expected beat stream {load_weight, tuser, tdata}.
   logic [RW-1:0]   w_m [N];
   logic [RW-1:0]   a_m [DEPTH];
   logic [RW+1:0]   exp_q [$];

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int rdy_mode = 0;
   bit capture_first = 0;
   logic [RW-1:0] first_beat = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // tready pattern: 0 always, 1 repeating 1,0,0,1, 2 random, 3 held low.
   initial begin
      int idx = 0;
      axis.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: axis.tready = 1'b1;
            1: axis.tready = ((idx % 4) == 0) || ((idx % 4) == 3);
            2: axis.tready = 1'($urandom_range(0, 1));
            default: axis.tready = 1'b0;
         endcase
         idx++;
      end
   end

   // Compare process: every accepted beat against the model, and beat
   // stability across every stall.
   logic [RW+1:0] prev_beat;
   bit            prev_stall = 0;
   always @(negedge clk) begin
      logic [RW+1:0] got;
      logic [RW+1:0] e;
      got = {load_weight, axis.tuser, axis.tdata};
      if (!reset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(axis.tvalid && got == prev_beat)) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b 0x%0h expected v=1 0x%0h at %0t",
                        axis.tvalid, got, prev_beat, $time);
            end
         end
         if (axis.tvalid && axis.tready) begin
            checks++;
            beats_seen++;
            if (capture_first) begin
               first_beat    = axis.tdata;
               capture_first = 0;
            end
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: got 0x%0h expected none at %0t", got, $time);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL beat: got lw/user/data 0x%0h expected 0x%0h at %0t", got, e, $time);
               end
            end
         end
         prev_stall = axis.tvalid && !axis.tready;
         prev_beat  = got;
      end
   end

   // Expected stream of one job, from the memory model and the job rules.
   task automatic build_job(input bit rl, input int nr);
      int rows_c;
      rows_c = (nr > DEPTH) ? DEPTH : nr;
      if (rl) for (int r = N - 1; r >= 0; r--) exp_q.push_back({1'b1, 1'b0, w_m[r]});
      for (int r = 0; r < rows_c; r++) exp_q.push_back({1'b0, 1'b0, a_m[r]});
      if (rows_c > 0) for (int f = 0; f < FL; f++) exp_q.push_back({1'b0, 1'b1, {RW{1'b0}}});
   endtask

   task automatic wr(input bit sel, input int addr, input logic [RW-1:0] d, input bit upd);
      @(posedge clk);
      #1;
      wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (upd) begin
         if (sel && addr < N) w_m[addr] = d;
         if (!sel && addr < DEPTH) a_m[addr] = d;
      end
   endtask

   task automatic run_job(input bit rl, input int nr, input int mode);
      int nb;
      int cyc;
      bit seen;
      exp_q.delete();
      build_job(rl, nr);
      nb = exp_q.size();
      rdy_mode = mode;
      @(posedge clk);
      #1;
      start = 1'b1; reload_w = rl; num_rows = 5'(nr);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", 64'(busy), 64'd1);
      check("first_valid", 64'(axis.tvalid), 64'(nb > 0));
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 3000) begin
         if (done) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      if (mode == 0) check("done_cycle", 64'(cyc), 64'(nb));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_not_busy", 64'(busy), 64'd0);
      check("idle_no_valid", 64'(axis.tvalid), 64'd0);
      check("beats_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int b0;
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int b0;
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("rst_tdata", 64'(axis.tdata), 64'd0);
      check("rst_tuser", 64'(axis.tuser), 64'd0);
      check("rst_lw", 64'(load_weight), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b1;

      // 1: defaults, full-rate job.
      for (int r = 0; r < N; r++) wr(1'b1, r, RW'(32'h04030201 * (r + 1)), 1'b1);
      for (int r = 0; r < 3; r++) wr(1'b0, r, RW'(32'hA0B0C000 + r), 1'b1);
      b0 = beats_seen;
      capture_first = 1;
      run_job(1'b1, 3, 0);
      check("t1_beats", 64'(beats_seen - b0), 64'd16);
      check("t1_first_beat", 64'(first_beat), 64'h100C0804);

      // 2: same job under 1,0,0,1 backpressure.
      b0 = beats_seen;
      run_job(1'b1, 3, 1);
      check("t2_beats", 64'(beats_seen - b0), 64'd16);

      // 3: full depth without weights, then clamped row count.
      for (int r = 0; r < DEPTH; r++) wr(1'b0, r, RW'($urandom), 1'b1);
      b0 = beats_seen;
      run_job(1'b0, 16, 0);
      check("t3_beats", 64'(beats_seen - b0), 64'd25);
      b0 = beats_seen;
      run_job(1'b0, 20, 2);
      check("t3_clamp_beats", 64'(beats_seen - b0), 64'd25);

      // 4: weight-only job, then an empty job.
      b0 = beats_seen;
      run_job(1'b1, 0, 0);
      check("t4_weight_only", 64'(beats_seen - b0), 64'd4);
      b0 = beats_seen;
      run_job(1'b0, 0, 0);
      check("t4_empty", 64'(beats_seen - b0), 64'd0);

      // Out-of-range weight address is dropped.
      wr(1'b1, 5, RW'(32'hDEADBEEF), 1'b0);

      // 5: start and writes while busy are ignored.
      fork
         run_job(1'b1, 3, 0);
         begin
            repeat (4) @(posedge clk);
            #1;
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = RW'(32'h55AA55AA); start = 1'b1;
            @(posedge clk);
            #1;
            wr_sel = 1'b1; wr_addr = 4'd3; wr_data = RW'(32'h66BB66BB);
            @(posedge clk);
            #1;
            wr_en = 1'b0; start = 1'b0;
         end
      join
      run_job(1'b1, 3, 2);

      // 6: asynchronous reset in a stalled ACT beat.
      exp_q.delete();
      build_job(1'b1, 5);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      start = 1'b1; reload_w = 1'b1; num_rows = 5'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (N + 1) @(negedge clk);
      rdy_mode = 3;
      repeat (3) @(negedge clk);
      check("t6_stall_valid", 64'(axis.tvalid), 64'd1);
      check("t6_stall_lw", 64'(load_weight), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_lw", 64'(load_weight), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_job(1'b1, 5, 2);

      // Randomized jobs with fresh memory contents.
      for (int j = 0; j < 6; j++) begin
         for (int k = 0; k < 3; k++) begin
            wr(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), RW'($urandom), 1'b1);
         end
         run_job(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
